// File: rtl/rx_iod_bit_align_mlane_pkg.sv
// Shared types and width helpers for the multi-lane RX IOD bit-align trainer.
package rx_iod_bit_align_mlane_pkg;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result = 0;
        for (int unsigned i = 0; i < 31; i++)
            if ((32'd1 << i) < value) result = i + 1;
        return result;
    endfunction

    function automatic int unsigned tap_width(input int unsigned tap_cnt);
        return clog2(tap_cnt);
    endfunction

    // A single-lane build still needs a 1-bit lane index.
    function automatic int unsigned lane_width(input int unsigned num_lanes);
        return (clog2(num_lanes) == 0) ? 1 : clog2(num_lanes);
    endfunction

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LANE_SEL,
        ST_LOAD,
        ST_CLR,
        ST_SETTLE,
        ST_SAMPLE,
        ST_STEP,
        ST_EVAL,
        ST_CENTER_LOAD,
        ST_CENTER_MOVE,
        ST_CENTER_GAP,
        ST_NEXT,
        ST_DONE
    } align_state_e;

endpackage

// File: rtl/rx_iod_bit_align_mlane_if.sv
// Control/status bundle between the bit-align sequencer (master) and the lane IODs/PLL logic (slave).
interface rx_iod_bit_align_mlane_if #(
    parameter int unsigned NUM_LANES = 4,
    parameter int unsigned TAP_CNT   = 256
);
    import rx_iod_bit_align_mlane_pkg::*;

    localparam int unsigned TAP_W  = tap_width(TAP_CNT);
    localparam int unsigned LANE_W = lane_width(NUM_LANES);

    logic                       PLL_LOCK;
    logic [NUM_LANES-1:0]       LANE_EN;
    logic                       ALGN_RSTRT;
    logic                       ALGN_HOLD;
    logic [NUM_LANES-1:0]       IOD_EARLY;
    logic [NUM_LANES-1:0]       IOD_LATE;
    logic [NUM_LANES-1:0]       IOD_OOR;
    logic [NUM_LANES-1:0]       BIT_ALGN_LOAD;
    logic [NUM_LANES-1:0]       BIT_ALGN_MOVE;
    logic [NUM_LANES-1:0]       BIT_ALGN_DIR;
    logic [NUM_LANES-1:0]       BIT_ALGN_CLR_FLGS;
    logic [NUM_LANES-1:0]       ALGN_DONE;
    logic [NUM_LANES-1:0]       ALGN_ERR;
    logic                       ALGN_BUSY;
    logic [LANE_W-1:0]          ACTIVE_LANE;
    logic [NUM_LANES*TAP_W-1:0] TAPDLY;

    modport master (
        input  PLL_LOCK, LANE_EN, ALGN_RSTRT, ALGN_HOLD, IOD_EARLY, IOD_LATE, IOD_OOR,
        output BIT_ALGN_LOAD, BIT_ALGN_MOVE, BIT_ALGN_DIR, BIT_ALGN_CLR_FLGS,
               ALGN_DONE, ALGN_ERR, ALGN_BUSY, ACTIVE_LANE, TAPDLY
    );

    modport slave (
        output PLL_LOCK, LANE_EN, ALGN_RSTRT, ALGN_HOLD, IOD_EARLY, IOD_LATE, IOD_OOR,
        input  BIT_ALGN_LOAD, BIT_ALGN_MOVE, BIT_ALGN_DIR, BIT_ALGN_CLR_FLGS,
               ALGN_DONE, ALGN_ERR, ALGN_BUSY, ACTIVE_LANE, TAPDLY
    );

endinterface

// File: rtl/rx_iod_bit_align_mlane_eye_window.sv
// Tracks the current run of good taps and the first longest run seen since the last clear.
module rx_iod_eye_window #(
    parameter int unsigned TAP_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             sample_valid,
    input  logic             good,
    input  logic [TAP_W-1:0] tap,
    output logic [TAP_W-1:0] best_start,
    output logic [TAP_W:0]   best_len
);

    logic [TAP_W:0]   run_len;
    logic [TAP_W-1:0] run_start;
    logic [TAP_W:0]   next_len;
    logic [TAP_W-1:0] next_start;

    always_comb begin
        next_len   = run_len + 1'b1;
        next_start = (run_len == '0) ? tap : run_start;
    end

    // Strict compare keeps the earliest window when lengths tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_len    <= '0;
            run_start  <= '0;
            best_len   <= '0;
            best_start <= '0;
        end else if (clear) begin
            run_len    <= '0;
            run_start  <= '0;
            best_len   <= '0;
            best_start <= '0;
        end else if (sample_valid) begin
            if (good) begin
                run_len   <= next_len;
                run_start <= next_start;
                if (next_len > best_len) begin
                    best_len   <= next_len;
                    best_start <= next_start;
                end
            end else begin
                run_len <= '0;
            end
        end
    end

endmodule

// File: rtl/rx_iod_bit_align_mlane.sv
// Multi-lane IOD bit-align trainer: sweeps each enabled lane's tap range, finds the widest eye and centres on it.
module rx_iod_bit_align_mlane
    import rx_iod_bit_align_mlane_pkg::*;
#(
    parameter int unsigned NUM_LANES  = 4,
    parameter int unsigned TAP_CNT    = 256,
    parameter int unsigned WAIT_W     = 3,
    parameter int unsigned MIN_WINDOW = 10
) (
    input  logic                      SCLK,
    input  logic                      RESET,
    rx_iod_bit_align_mlane_if.master  bus
);

    localparam int unsigned TAP_W  = tap_width(TAP_CNT);
    localparam int unsigned LANE_W = lane_width(NUM_LANES);
    localparam logic [TAP_W-1:0]  TAP_LAST  = TAP_W'(TAP_CNT - 1);
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(NUM_LANES - 1);
    localparam logic [TAP_W:0]    MIN_LEN   = (TAP_W + 1)'(MIN_WINDOW);

    align_state_e state, state_nxt;

    logic [LANE_W-1:0]          lane;
    logic [TAP_W-1:0]           tap;
    logic [WAIT_W-1:0]          wait_cnt;
    logic [TAP_W-1:0]           move_cnt;
    logic [TAP_W-1:0]           target;
    logic [NUM_LANES-1:0]       done;
    logic [NUM_LANES-1:0]       err;
    logic [NUM_LANES*TAP_W-1:0] tapdly;

    logic [TAP_W-1:0] best_start;
    logic [TAP_W:0]   best_len;
    logic [NUM_LANES-1:0] lane_bit;
    logic lane_en, lane_good, lane_oor, sweep_end, window_ok, pll_drop, advance;

    assign lane_en   = bus.LANE_EN[lane];
    assign lane_good = ~(bus.IOD_EARLY[lane] | bus.IOD_LATE[lane]);
    assign lane_oor  = bus.IOD_OOR[lane];
    assign sweep_end = (tap == TAP_LAST) || lane_oor;
    assign window_ok = (best_len >= MIN_LEN);
    assign pll_drop  = !bus.PLL_LOCK && (state != ST_IDLE);
    assign advance   = !bus.ALGN_HOLD && !pll_drop;

    rx_iod_eye_window #(.TAP_W(TAP_W)) u_eye_window (
        .clk          (SCLK),
        .rst          (RESET),
        .clear        (advance && (state == ST_LOAD)),
        .sample_valid (advance && (state == ST_SAMPLE)),
        .good         (lane_good),
        .tap          (tap),
        .best_start   (best_start),
        .best_len     (best_len)
    );

    always_ff @(posedge SCLK or posedge RESET) begin
        if (RESET) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (pll_drop) begin
            state_nxt = ST_IDLE;
        end else if (!bus.ALGN_HOLD) begin
            unique case (state)
                ST_IDLE:        if (bus.PLL_LOCK) state_nxt = ST_LANE_SEL;
                ST_LANE_SEL:    state_nxt = lane_en ? ST_LOAD : ST_NEXT;
                ST_LOAD:        state_nxt = ST_CLR;
                ST_CLR:         state_nxt = ST_SETTLE;
                ST_SETTLE:      if (wait_cnt == '1) state_nxt = ST_SAMPLE;
                ST_SAMPLE:      state_nxt = sweep_end ? ST_EVAL : ST_STEP;
                ST_STEP:        state_nxt = ST_CLR;
                ST_EVAL:        state_nxt = window_ok ? ST_CENTER_LOAD : ST_NEXT;
                ST_CENTER_LOAD: state_nxt = (target == '0) ? ST_NEXT : ST_CENTER_MOVE;
                ST_CENTER_MOVE: state_nxt = ST_CENTER_GAP;
                ST_CENTER_GAP:  state_nxt = (move_cnt == target) ? ST_NEXT : ST_CENTER_MOVE;
                ST_NEXT:        state_nxt = (lane == LANE_LAST) ? ST_DONE : ST_LANE_SEL;
                ST_DONE:        if (bus.ALGN_RSTRT) state_nxt = ST_LANE_SEL;
                default:        state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        lane_bit       = '0;
        lane_bit[lane] = 1'b1;
        bus.BIT_ALGN_LOAD     = '0;
        bus.BIT_ALGN_MOVE     = '0;
        bus.BIT_ALGN_DIR      = '0;
        bus.BIT_ALGN_CLR_FLGS = '0;
        if (advance) begin
            unique case (state)
                ST_LOAD, ST_CENTER_LOAD: bus.BIT_ALGN_LOAD = lane_bit;
                ST_EVAL:                 if (!window_ok) bus.BIT_ALGN_LOAD = lane_bit;
                ST_CLR:                  bus.BIT_ALGN_CLR_FLGS = lane_bit;
                ST_STEP, ST_CENTER_MOVE: begin
                    bus.BIT_ALGN_MOVE = lane_bit;
                    bus.BIT_ALGN_DIR  = lane_bit;
                end
                default: ;
            endcase
        end
        bus.ALGN_BUSY = (state != ST_IDLE) && (state != ST_DONE);
    end

    // Lane bookkeeping; a lost PLL clears results even while held.
    always_ff @(posedge SCLK or posedge RESET) begin
        if (RESET) begin
            lane     <= '0;
            tap      <= '0;
            wait_cnt <= '0;
            move_cnt <= '0;
            target   <= '0;
            done     <= '0;
            err      <= '0;
            tapdly   <= '0;
        end else if (pll_drop) begin
            lane   <= '0;
            done   <= '0;
            err    <= '0;
            tapdly <= '0;
        end else if (!bus.ALGN_HOLD) begin
            unique case (state)
                ST_IDLE: lane <= '0;
                ST_LANE_SEL: if (!lane_en) begin
                    done[lane] <= 1'b1;
                    err[lane]  <= 1'b0;
                    tapdly[lane*TAP_W +: TAP_W] <= '0;
                end
                ST_LOAD:   tap      <= '0;
                ST_CLR:    wait_cnt <= '0;
                ST_SETTLE: wait_cnt <= wait_cnt + 1'b1;
                ST_STEP:   tap      <= tap + 1'b1;
                ST_EVAL: begin
                    if (!window_ok) begin
                        done[lane] <= 1'b1;
                        err[lane]  <= 1'b1;
                        tapdly[lane*TAP_W +: TAP_W] <= '0;
                    end else begin
                        target <= best_start + best_len[TAP_W:1];
                    end
                end
                ST_CENTER_LOAD: begin
                    move_cnt <= '0;
                    if (target == '0) begin
                        done[lane] <= 1'b1;
                        err[lane]  <= 1'b0;
                        tapdly[lane*TAP_W +: TAP_W] <= target;
                    end
                end
                ST_CENTER_MOVE: move_cnt <= move_cnt + 1'b1;
                ST_CENTER_GAP: if (move_cnt == target) begin
                    done[lane] <= 1'b1;
                    err[lane]  <= 1'b0;
                    tapdly[lane*TAP_W +: TAP_W] <= target;
                end
                ST_NEXT: if (lane != LANE_LAST) lane <= lane + 1'b1;
                ST_DONE: if (bus.ALGN_RSTRT) begin
                    done <= done & ~bus.LANE_EN;
                    err  <= err & ~bus.LANE_EN;
                    lane <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.ALGN_DONE   = done;
    assign bus.ALGN_ERR    = err;
    assign bus.ACTIVE_LANE = lane;
    assign bus.TAPDLY      = tapdly;

endmodule

// File: tb/tb_rx_iod_bit_align_mlane.sv
// Directed bench for rx_iod_bit_align_mlane: two lanes, 32 taps, behavioural IOD tap/flag model.
module tb_rx_iod_bit_align_mlane;

    localparam int unsigned NL = 2;
    localparam int unsigned TC = 32;

    logic SCLK  = 1'b0;
    logic RESET = 1'b1;
    always #5 SCLK = ~SCLK;

    rx_iod_bit_align_mlane_if #(.NUM_LANES(NL), .TAP_CNT(TC)) bus ();

    rx_iod_bit_align_mlane #(
        .NUM_LANES  (NL),
        .TAP_CNT    (TC),
        .WAIT_W     (2),
        .MIN_WINDOW (4)
    ) dut (
        .SCLK  (SCLK),
        .RESET (RESET),
        .bus   (bus.master)
    );

    logic [31:0] good_mask [NL];
    int          oor_tap   [NL];
    int          tap_m     [NL];
    int          load_cnt  [NL];
    int          move_cnt  [NL];
    int          stray;
    int          hold_strobes;
    logic        cnt_clr;
    int          vectors;
    int          miscompares;

    logic [NL-1:0] strobes, active_mask;
    assign strobes     = bus.BIT_ALGN_LOAD | bus.BIT_ALGN_MOVE | bus.BIT_ALGN_DIR | bus.BIT_ALGN_CLR_FLGS;
    assign active_mask = NL'(1) << bus.ACTIVE_LANE;

    // IOD model: lane 0 reports bad taps as EARLY, lane 1 as LATE.
    always_comb begin
        logic [NL-1:0] e, l, o;
        logic g;
        e = '0; l = '0; o = '0; g = 1'b0;
        for (int i = 0; i < NL; i++) begin
            g = (tap_m[i] >= 0 && tap_m[i] < TC) ? good_mask[i][5'(tap_m[i])] : 1'b0;
            if (i == 0) e[i] = !g;
            else        l[i] = !g;
            o[i] = (oor_tap[i] >= 0) && (tap_m[i] >= oor_tap[i]);
        end
        bus.IOD_EARLY = e;
        bus.IOD_LATE  = l;
        bus.IOD_OOR   = o;
    end

    always @(posedge SCLK) begin
        for (int i = 0; i < NL; i++) begin
            if (bus.BIT_ALGN_LOAD[i])                         tap_m[i] <= 0;
            else if (bus.BIT_ALGN_MOVE[i] && bus.BIT_ALGN_DIR[i]) tap_m[i] <= tap_m[i] + 1;
        end
        if (cnt_clr) begin
            for (int i = 0; i < NL; i++) begin
                load_cnt[i] <= 0;
                move_cnt[i] <= 0;
            end
            stray        <= 0;
            hold_strobes <= 0;
        end else begin
            for (int i = 0; i < NL; i++) begin
                if (bus.BIT_ALGN_LOAD[i]) load_cnt[i] <= load_cnt[i] + 1;
                if (bus.BIT_ALGN_MOVE[i]) move_cnt[i] <= move_cnt[i] + 1;
            end
            if ((strobes & ~active_mask) != '0)       stray        <= stray + 1;
            if (bus.ALGN_HOLD && (strobes != '0))     hold_strobes <= hold_strobes + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge SCLK);
        #1;
    endtask

    function automatic logic [31:0] win(input int lo, input int hi);
        logic [31:0] m = '0;
        for (int t = lo; t <= hi; t++) m[t] = 1'b1;
        return m;
    endfunction

    task automatic configure(input logic [31:0] m0, input logic [31:0] m1, input int oor0, input logic [NL-1:0] en);
        good_mask[0] = m0;
        good_mask[1] = m1;
        oor_tap[0]   = oor0;
        oor_tap[1]   = -1;
        bus.LANE_EN  = en;
    endtask

    task automatic start_run();
        RESET          = 1'b1;
        bus.PLL_LOCK   = 1'b0;
        bus.ALGN_RSTRT = 1'b0;
        bus.ALGN_HOLD  = 1'b0;
        cnt_clr        = 1'b1;
        tick(2);
        RESET        = 1'b0;
        cnt_clr      = 1'b0;
        bus.PLL_LOCK = 1'b1;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (bus.ALGN_BUSY !== 1'b1 && n < 100) begin tick(); n++; end
        while (bus.ALGN_BUSY === 1'b1 && n < 6000) begin tick(); n++; end
        check({tag, "_busy_fall"}, 32'(bus.ALGN_BUSY), 0);
        check({tag, "_stray_strobe"}, 32'(stray), 0);
    endtask

    // Wait for the nth pulse of LOAD (kind 0) or CLR_FLGS (kind 1) on one lane.
    task automatic wait_pulse(input int kind, input int ln, input int nth, input string tag);
        int seen = 0;
        int n    = 0;
        while (seen < nth && n < 3000) begin
            tick();
            n++;
            if ((kind == 0) ? bus.BIT_ALGN_LOAD[ln] : bus.BIT_ALGN_CLR_FLGS[ln]) seen++;
        end
        if (seen < nth) check({tag, "_pulse_timeout"}, 32'(seen), 32'(nth));
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        cnt_clr = 1'b1;
        bus.PLL_LOCK = 1'b0;
        bus.ALGN_RSTRT = 1'b0;
        bus.ALGN_HOLD = 1'b0;
        configure(win(10, 19), win(0, 31), -1, 2'b11);
        for (int i = 0; i < NL; i++) tap_m[i] = 0;

        tick(3);
        check("rst_done",   32'(bus.ALGN_DONE), 0);
        check("rst_err",    32'(bus.ALGN_ERR), 0);
        check("rst_tapdly", 32'(bus.TAPDLY), 0);
        check("rst_busy",   32'(bus.ALGN_BUSY), 0);
        check("rst_strobe", 32'(strobes), 0);
        check("rst_lane",   32'(bus.ACTIVE_LANE), 0);

        // Basic two-lane training
        start_run();
        wait_done("t1");
        check("t1_tap0",  32'(bus.TAPDLY[4:0]), 15);
        check("t1_tap1",  32'(bus.TAPDLY[9:5]), 16);
        check("t1_done",  32'(bus.ALGN_DONE), 3);
        check("t1_err",   32'(bus.ALGN_ERR), 0);
        check("t1_iod0",  32'(tap_m[0]), 15);
        check("t1_iod1",  32'(tap_m[1]), 16);
        check("t1_load0", 32'(load_cnt[0]), 2);
        check("t1_move0", 32'(move_cnt[0]), 46);
        check("t1_move1", 32'(move_cnt[1]), 47);

        // Lane 1 window too narrow
        configure(win(10, 19), win(3, 5), -1, 2'b11);
        start_run();
        wait_done("t2");
        check("t2_done", 32'(bus.ALGN_DONE), 3);
        check("t2_err",  32'(bus.ALGN_ERR), 2);
        check("t2_tap1", 32'(bus.TAPDLY[9:5]), 0);
        check("t2_tap0", 32'(bus.TAPDLY[4:0]), 15);
        check("t2_iod1", 32'(tap_m[1]), 0);

        // Equal-length windows: first one wins
        configure(win(2, 7) | win(20, 25), win(0, 31), -1, 2'b11);
        start_run();
        wait_done("t3a");
        check("t3a_tap0", 32'(bus.TAPDLY[4:0]), 5);
        check("t3a_err",  32'(bus.ALGN_ERR), 0);

        configure(win(2, 7) | win(20, 26), win(0, 31), -1, 2'b11);
        start_run();
        wait_done("t3b");
        check("t3b_tap0", 32'(bus.TAPDLY[4:0]), 23);
        check("t3b_tap1", 32'(bus.TAPDLY[9:5]), 16);

        // Lane 0 disabled
        configure(win(10, 19), win(0, 31), -1, 2'b10);
        start_run();
        wait_done("t4");
        check("t4_done",  32'(bus.ALGN_DONE), 3);
        check("t4_err",   32'(bus.ALGN_ERR), 0);
        check("t4_load0", 32'(load_cnt[0]), 0);
        check("t4_move0", 32'(move_cnt[0]), 0);
        check("t4_tap0",  32'(bus.TAPDLY[4:0]), 0);
        check("t4_tap1",  32'(bus.TAPDLY[9:5]), 16);

        // Out-of-range stops the sweep at tap 12
        configure(win(4, 12), win(0, 31), 12, 2'b11);
        start_run();
        wait_done("t5");
        check("t5_tap0",  32'(bus.TAPDLY[4:0]), 8);
        check("t5_move0", 32'(move_cnt[0]), 20);
        check("t5_done",  32'(bus.ALGN_DONE), 3);

        // Hold for 50 cycles inside a settle period
        start_run();
        wait_pulse(1, 0, 5, "t6");
        tick(2);
        bus.ALGN_HOLD = 1'b1;
        tick(50);
        check("t6_hold_strobes", 32'(hold_strobes), 0);
        check("t6_hold_busy",    32'(bus.ALGN_BUSY), 1);
        check("t6_hold_done",    32'(bus.ALGN_DONE), 0);
        bus.ALGN_HOLD = 1'b0;
        wait_done("t6");
        check("t6_tap0",  32'(bus.TAPDLY[4:0]), 8);
        check("t6_move0", 32'(move_cnt[0]), 20);
        check("t6_tap1",  32'(bus.TAPDLY[9:5]), 16);

        // Async reset while centring lane 1
        configure(win(10, 19), win(0, 31), -1, 2'b11);
        start_run();
        wait_pulse(0, 1, 2, "t7");
        tick(3);
        check("t7_pre_done", 32'(bus.ALGN_DONE), 1);
        #2 RESET = 1'b1;
        #1;
        check("t7_done",   32'(bus.ALGN_DONE), 0);
        check("t7_tapdly", 32'(bus.TAPDLY), 0);
        check("t7_busy",   32'(bus.ALGN_BUSY), 0);
        check("t7_strobe", 32'(strobes), 0);
        check("t7_lane",   32'(bus.ACTIVE_LANE), 0);
        tick(1);
        RESET = 1'b0;

        // PLL lock lost mid-sweep, then relock
        start_run();
        begin
            int n = 0;
            while (bus.ACTIVE_LANE != 1 && n < 2000) begin tick(); n++; end
        end
        tick(20);
        check("t8_pre_tap0", 32'(bus.TAPDLY[4:0]), 15);
        bus.PLL_LOCK = 1'b0;
        tick(1);
        check("t8_done",   32'(bus.ALGN_DONE), 0);
        check("t8_tapdly", 32'(bus.TAPDLY), 0);
        check("t8_busy",   32'(bus.ALGN_BUSY), 0);
        tick(3);
        bus.PLL_LOCK = 1'b1;
        begin
            int n = 0;
            while (bus.BIT_ALGN_LOAD == '0 && n < 20) begin tick(); n++; end
        end
        check("t8_relock_load", 32'(bus.BIT_ALGN_LOAD), 1);
        check("t8_relock_lane", 32'(bus.ACTIVE_LANE), 0);
        wait_done("t8");
        check("t8_tap0", 32'(bus.TAPDLY[4:0]), 15);
        check("t8_tap1", 32'(bus.TAPDLY[9:5]), 16);
        check("t8_fin_done", 32'(bus.ALGN_DONE), 3);

        // Retrain request from DONE
        bus.ALGN_RSTRT = 1'b1;
        tick(1);
        bus.ALGN_RSTRT = 1'b0;
        check("t9_done_clr", 32'(bus.ALGN_DONE), 0);
        check("t9_busy",     32'(bus.ALGN_BUSY), 1);
        wait_done("t9");
        check("t9_tap0", 32'(bus.TAPDLY[4:0]), 15);
        check("t9_tap1", 32'(bus.TAPDLY[9:5]), 16);
        check("t9_done", 32'(bus.ALGN_DONE), 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
